y86_execute_stage: RTL and testbench

Registered Execute stage for the Y86-64 processor. Accepts a decoded instruction (icode, ifun, valA, valB, valC), selects ALU operands and function, computes valE and the branch/conditional-move flag Cnd, and maintains the condition-code register (ZF, SF, OF). Sits between Decode and Memory. Valid/ready handshake on both sides, with a single output register.

---
 rtl/y86_pkg.sv | 61 ++++++
 rtl/y86_execute_stage_if.sv | 34 +++
 rtl/y86_alu.sv | 53 +++++
 rtl/y86_execute_stage.sv | 121 ++++++++++++
 tb/tb_y86_execute_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, ALU functions, branch/move
// condition codes, the condition-code register type and its evaluator.
package y86_pkg;

  typedef logic [63:0] word_t;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU functions, encoded exactly as OPq ifun[1:0]
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_e;

  // Condition codes carried in ifun of jXX / cmovXX
  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  // Undefined condition codes evaluate false; they are flagged as exceptions
  // by the execute stage anyway.
  function automatic logic cond_eval(input cc_t cc, input logic [3:0] fn);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (fn)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | cc.zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = cc.zf;
      C_NE:    cond_eval = ~cc.zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~cc.zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_execute_stage_if.sv
// Execute-stage bus: Decode-side input handshake with the decoded instruction,
// Memory-side output handshake with the registered results, and the current
// condition codes.
//   slave  : used by the execute stage
//   master : used by whatever drives Decode/Memory (or a testbench)
interface y86_execute_stage_if;
  import y86_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  word_t       valA;
  word_t       valB;
  word_t       valC;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  e_icode;
  word_t       e_valE;
  word_t       e_valA;
  logic        e_cnd;
  logic        e_exc;
  cc_t         cc;

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, out_ready,
    output in_ready, out_valid, e_icode, e_valE, e_valA, e_cnd, e_exc, cc
  );

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, out_ready,
    input  in_ready, out_valid, e_icode, e_valE, e_valA, e_cnd, e_exc, cc
  );
endinterface

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: result = b op a for add/sub/and/xor, plus the
// zero/sign/overflow flags of that result.
//   a, b   : operands (aluA, aluB)
//   fn     : ALU function
//   result : b op a, modulo 2^W
//   zf, sf, of : flags of result
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_fn_e      fn,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  logic [W-1:0] addend;
  logic [W-1:0] sum;
  logic         carry;

  // Ripple adder; subtraction is b + ~a + 1.
  // NOTE: every always_comb output gets a default before any branch or loop,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    addend = (fn == ALU_SUB) ? ~a : a;
    carry  = (fn == ALU_SUB);
    sum    = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = b[i] ^ addend[i] ^ carry;
      carry  = (b[i] & addend[i]) | (carry & (b[i] ^ addend[i]));
    end
  end

  always_comb begin
    result = sum;
    of     = 1'b0;
    case (fn)
      ALU_ADD: of = (a[W-1] == b[W-1]) && (sum[W-1] != b[W-1]);
      ALU_SUB: of = (a[W-1] != b[W-1]) && (sum[W-1] != b[W-1]);
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = sum;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[W-1];

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 Execute stage with a single output register. Selects ALU operands
// from the decoded instruction, computes valE and Cnd, maintains the
// {ZF,SF,OF} condition codes and flags invalid instructions.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : y86_execute_stage_if.slave (input handshake + instruction,
//         output handshake + registered results, current cc)
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  y86_execute_stage_if.slave       bus
);

  logic         out_valid_q;
  logic [3:0]   e_icode_q;
  word_t        e_valE_q;
  word_t        e_valA_q;
  logic         e_cnd_q;
  logic         e_exc_q;
  cc_t          cc_q;

  word_t        alu_a;
  word_t        alu_b;
  alu_fn_e      alu_fn;
  word_t        alu_result;
  logic         alu_zf;
  logic         alu_sf;
  logic         alu_of;
  logic         exc;
  logic         accept;
  logic         is_cond;

  // Reset forces readiness so the stage is never seen as stalled while
  // inputs are being ignored.
  assign bus.in_ready = rst | ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready & ~rst;
  assign is_cond      = (bus.icode == I_RRMOVQ) || (bus.icode == I_JXX);

  // Operand selection: valE = alu_b (fn) alu_a.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = ALU_ADD;
    exc    = 1'b0;
    case (bus.icode)
      I_HALT, I_NOP, I_JXX: begin
      end
      I_RRMOVQ: alu_a = bus.valA;
      I_IRMOVQ: alu_a = bus.valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = bus.valC;
        alu_b = bus.valB;
      end
      I_OPQ: begin
        alu_a  = bus.valA;
        alu_b  = bus.valB;
        alu_fn = alu_fn_e'(bus.ifun[1:0]);
        exc    = (bus.ifun > 4'd3);
      end
      I_CALL, I_PUSHQ: begin
        alu_a = -64'sd8;
        alu_b = bus.valB;
      end
      I_RET, I_POPQ: begin
        alu_a = 64'd8;
        alu_b = bus.valB;
      end
      default: exc = 1'b1;
    endcase
    if (is_cond && bus.ifun > 4'd6) exc = 1'b1;
  end

  y86_alu #(.W(W)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fn     (alu_fn),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Cnd samples cc_q, i.e. the flags from before any update on this edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      e_icode_q   <= I_NOP;
      e_valE_q    <= '0;
      e_valA_q    <= '0;
      e_cnd_q     <= 1'b0;
      e_exc_q     <= 1'b0;
      cc_q        <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    end else if (accept) begin
      out_valid_q <= 1'b1;
      e_icode_q   <= bus.icode;
      e_valE_q    <= exc ? '0 : alu_result;
      e_valA_q    <= bus.valA;
      e_cnd_q     <= ~exc & is_cond & cond_eval(cc_q, bus.ifun);
      e_exc_q     <= exc;
      if (bus.icode == I_OPQ && !exc)
        cc_q <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.e_icode   = e_icode_q;
  assign bus.e_valE    = e_valE_q;
  assign bus.e_valA    = e_valA_q;
  assign bus.e_cnd     = e_cnd_q;
  assign bus.e_exc     = e_exc_q;
  assign bus.cc        = cc_q;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed self-checking bench for y86_execute_stage.
module tb_y86_execute_stage;
  import y86_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  y86_execute_stage_if bus ();

  y86_execute_stage #(.W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c);
    bus.in_valid = 1'b1;
    bus.icode    = ic;
    bus.ifun     = fn;
    bus.valA     = a;
    bus.valB     = b;
    bus.valC     = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(I_OPQ, 4'd0, 64'd1, 64'd1, 64'd0);
    bus.in_valid = 1'b0;
    step();
    step();
    bus.in_valid = 1'b1;   // ignored while rst=1
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.e_icode !== 4'h1) begin errors++; $display("FAIL rst_e_icode: got %h expected 1", bus.e_icode); end
    checks++; if (bus.e_valE !== 64'd0 || bus.e_valA !== 64'd0) begin errors++; $display("FAIL rst_vals: got %h/%h expected 0/0", bus.e_valE, bus.e_valA); end
    checks++; if (bus.e_cnd !== 1'b0 || bus.e_exc !== 1'b0) begin errors++; $display("FAIL rst_cnd_exc: got %b/%b expected 0/0", bus.e_cnd, bus.e_exc); end
    checks++; if (bus.cc !== 3'b100) begin errors++; $display("FAIL rst_cc: got %b expected 100", bus.cc); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_add_overflow();
    drive(I_OPQ, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    step();
    checks++; if (bus.e_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_valE: got %h expected 8000000000000000", bus.e_valE); end
    checks++; if (bus.cc !== 3'b011) begin errors++; $display("FAIL add_cc: got %b expected 011", bus.cc); end
    checks++; if (bus.out_valid !== 1'b1 || bus.e_icode !== I_OPQ) begin errors++; $display("FAIL add_valid_icode: got %b/%h expected 1/6", bus.out_valid, bus.e_icode); end
  endtask

  task automatic test_sub_je();
    drive(I_OPQ, 4'd1, 64'd5, 64'd5, 64'd0);
    step();
    checks++; if (bus.e_valE !== 64'd0) begin errors++; $display("FAIL sub_valE: got %h expected 0", bus.e_valE); end
    checks++; if (bus.cc !== 3'b100) begin errors++; $display("FAIL sub_cc: got %b expected 100", bus.cc); end
    drive(I_JXX, C_E, 64'd0, 64'd0, 64'h40);
    step();
    checks++; if (bus.e_cnd !== 1'b1 || bus.e_icode !== I_JXX) begin errors++; $display("FAIL je_cnd: got %b/%h expected 1/7", bus.e_cnd, bus.e_icode); end
    checks++; if (bus.e_valE !== 64'd0) begin errors++; $display("FAIL je_valE: got %h expected 0", bus.e_valE); end
    drive(I_JXX, C_NE, 64'd0, 64'd0, 64'h40);
    step();
    checks++; if (bus.e_cnd !== 1'b0) begin errors++; $display("FAIL jne_cnd: got %b expected 0", bus.e_cnd); end
  endtask

  task automatic test_stack();
    drive(I_PUSHQ, 4'd0, 64'h55, 64'h100, 64'd0);
    step();
    checks++; if (bus.e_valE !== 64'hF8 || bus.e_valA !== 64'h55) begin errors++; $display("FAIL push_valE: got %h/%h expected f8/55", bus.e_valE, bus.e_valA); end
    drive(I_RET, 4'd0, 64'h0, 64'hF8, 64'd0);
    step();
    checks++; if (bus.e_valE !== 64'h100) begin errors++; $display("FAIL ret_valE: got %h expected 100", bus.e_valE); end
    drive(I_MRMOVQ, 4'd0, 64'h0, 64'h1000, 64'h20);
    step();
    checks++; if (bus.e_valE !== 64'h1020) begin errors++; $display("FAIL mrmov_valE: got %h expected 1020", bus.e_valE); end
    drive(I_IRMOVQ, 4'd0, 64'h0, 64'h0, 64'hDEAD);
    step();
    checks++; if (bus.e_valE !== 64'hDEAD) begin errors++; $display("FAIL irmov_valE: got %h expected dead", bus.e_valE); end
    checks++; if (bus.cc !== 3'b100) begin errors++; $display("FAIL stack_cc: got %b expected 100", bus.cc); end
  endtask

  task automatic test_cmovl();
    // 1 - 2 = -1: ZF=0 SF=1 OF=0
    drive(I_OPQ, 4'd1, 64'd2, 64'd1, 64'd0);
    step();
    checks++; if (bus.e_valE !== 64'hFFFF_FFFF_FFFF_FFFF || bus.cc !== 3'b010) begin errors++; $display("FAIL neg_sub: got %h/%b expected ffffffffffffffff/010", bus.e_valE, bus.cc); end
    drive(I_RRMOVQ, C_L, 64'hABCD, 64'h9, 64'd0);
    step();
    checks++; if (bus.e_cnd !== 1'b1 || bus.e_valE !== 64'hABCD) begin errors++; $display("FAIL cmovl: got %b/%h expected 1/abcd", bus.e_cnd, bus.e_valE); end
    drive(I_JXX, C_G, 64'd0, 64'd0, 64'd0);
    step();
    checks++; if (bus.e_cnd !== 1'b0) begin errors++; $display("FAIL jg: got %b expected 0", bus.e_cnd); end
    drive(I_IRMOVQ, C_YES, 64'd0, 64'd0, 64'd7);
    step();
    checks++; if (bus.e_cnd !== 1'b0) begin errors++; $display("FAIL irmov_cnd: got %b expected 0", bus.e_cnd); end
  endtask

  task automatic test_stall();
    drive(I_OPQ, 4'd0, 64'd1, 64'd2, 64'd0);     // A: 2+1 = 3, cc 000
    step();
    checks++; if (bus.e_valE !== 64'd3 || bus.cc !== 3'b000) begin errors++; $display("FAIL stall_a: got %h/%b expected 3/000", bus.e_valE, bus.cc); end
    bus.out_ready = 1'b0;
    drive(I_OPQ, 4'd3, 64'hF0, 64'hFF, 64'd0);   // B: ff ^ f0 = 0f
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.e_valE !== 64'd3 || bus.out_valid !== 1'b1 || bus.cc !== 3'b000 || bus.in_ready !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d: got %h/%b/%b/%b expected 3/1/000/0", i, bus.e_valE, bus.out_valid, bus.cc, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.e_valE !== 64'h0F || bus.cc !== 3'b000) begin errors++; $display("FAIL release_b: got %h/%b expected f/000", bus.e_valE, bus.cc); end
    drive(I_OPQ, 4'd2, 64'hF0, 64'h0F, 64'd0);   // C: 0f & f0 = 0
    step();
    checks++; if (bus.e_valE !== 64'd0 || bus.cc !== 3'b100) begin errors++; $display("FAIL release_c: got %h/%b expected 0/100", bus.e_valE, bus.cc); end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_exc();
    drive(4'hC, 4'd0, 64'h11, 64'h22, 64'h33);
    step();
    checks++; if (bus.e_exc !== 1'b1 || bus.e_valE !== 64'd0 || bus.cc !== 3'b100) begin errors++; $display("FAIL exc_icode: got %b/%h/%b expected 1/0/100", bus.e_exc, bus.e_valE, bus.cc); end
    drive(I_OPQ, 4'd7, 64'd1, 64'd2, 64'd0);
    step();
    checks++; if (bus.e_exc !== 1'b1 || bus.e_valE !== 64'd0 || bus.cc !== 3'b100) begin errors++; $display("FAIL exc_opq: got %b/%h/%b expected 1/0/100", bus.e_exc, bus.e_valE, bus.cc); end
    drive(I_RRMOVQ, 4'd7, 64'h99, 64'd0, 64'd0);
    step();
    checks++; if (bus.e_exc !== 1'b1 || bus.e_valE !== 64'd0 || bus.e_cnd !== 1'b0) begin errors++; $display("FAIL exc_cmov: got %b/%h/%b expected 1/0/0", bus.e_exc, bus.e_valE, bus.e_cnd); end
    drive(I_OPQ, 4'd3, 64'd1, 64'd2, 64'd0);     // boundary ifun 3 is valid
    step();
    checks++; if (bus.e_exc !== 1'b0 || bus.e_valE !== 64'd3) begin errors++; $display("FAIL opq_ifun3: got %b/%h expected 0/3", bus.e_exc, bus.e_valE); end
  endtask

  task automatic test_reset_stall();
    drive(I_OPQ, 4'd1, 64'd2, 64'd1, 64'd0);     // cc -> 010
    step();
    bus.out_ready = 1'b0;
    drive(I_OPQ, 4'd0, 64'd0, 64'd0, 64'd0);     // would set ZF if accepted
    step();
    checks++; if (bus.cc !== 3'b010 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_stall: got %b/%b expected 010/1", bus.cc, bus.out_valid); end
    rst = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.cc !== 3'b100 || bus.e_icode !== 4'h1) begin errors++; $display("FAIL rst_stall: got %b/%b/%h expected 0/100/1", bus.out_valid, bus.cc, bus.e_icode); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_add_overflow();
    test_sub_je();
    test_stack();
    test_cmovl();
    test_stall();
    test_exc();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
